pcileech_tx_gearbox: RTL

- Sits between the command/readout FIFO controller (256-bit tx side) and the FT601 controller (32-bit din side).
- Buffers 256-bit beats and serialises each into eight 32-bit words, low dword first.
- Inserts a preamble of magic DWORDs at the start of each new burst, after the USB link has gone idle. The preamble forces the FTDI host to terminate transfers whose length is an exact multiple of 1024 bytes.
- Replaces the two cascaded output FIFOs and the ad-hoc magic-insert logic at the board top level.

---
 rtl/pcileech_tx_pkg.sv | 24 ++
 rtl/pcileech_tx_skid.sv | 49 ++++
 rtl/pcileech_tx_gearbox.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pcileech_tx_pkg.sv
// Shared types and constants for the 256-to-32 FT601 transmit gearbox.
// Optional preamble insertion is controlled by PCILEECH_FTDI_WORKAROUND_EN.
package pcileech_tx_pkg;

  localparam int BEAT_W = 256;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 3;

  localparam logic [31:0] MAGIC_WORD_DEFAULT = 32'h6666_5555;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA
  } tx_state_e;

  function automatic logic [WORD_W-1:0] beat_word(
    input logic [BEAT_W-1:0] beat,
    input logic [IDX_W-1:0]  idx
  );
    return beat[{idx, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/pcileech_tx_skid.sv
// Two-entry 256-bit beat buffer; entry 0 is always the head.
// Push and pop may coincide at any occupancy.
module pcileech_tx_skid
  import pcileech_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BEAT_W-1:0] push_data,
  input  logic              pop,
  output logic [BEAT_W-1:0] head,
  output logic [1:0]        occ
);

  logic [BEAT_W-1:0] ent0;
  logic [BEAT_W-1:0] ent1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;

endmodule

// File: rtl/pcileech_tx_gearbox.sv
// Serialises 256-bit beats into 32-bit FT601 words, low dword first.
// PCILEECH_FTDI_WORKAROUND_EN adds a magic-word preamble after link idle.
module pcileech_tx_gearbox
  import pcileech_tx_pkg::*;
#(
  parameter logic [31:0] MAGIC_WORD      = MAGIC_WORD_DEFAULT,
  parameter int          MAGIC_COUNT     = 5,
  parameter int          IDLE_ARM_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              ft601_txe_n,
  output logic [WORD_W-1:0] dout,
  output logic              empty,
  input  logic              rd_en,
  output logic              valid
);

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [WORD_W-1:0] dout_nxt;
  logic              run_q;
  logic              push;
  logic              pop;
  logic              rd_acc;
  logic [BEAT_W-1:0] head;
  logic [1:0]        occ;

`ifdef PCILEECH_FTDI_WORKAROUND_EN
  logic       txe_q;
  logic       armed;
  logic       armed_nxt;
  logic [3:0] mcnt;
  logic [3:0] mcnt_nxt;
  logic [7:0] idle_cnt;
  logic [7:0] idle_nxt;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ft601_txe_n, MAGIC_WORD,
                        MAGIC_COUNT, IDLE_ARM_CYCLES};
`endif

  // run_q keeps s_ready low until the first edge after reset release
  assign s_ready = run_q & (occ != 2'd2);
  assign push    = s_valid & s_ready;
  assign empty   = (state == IDLE);
  assign rd_acc  = rd_en & ~empty;

  pcileech_tx_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dout_nxt  = dout;
    pop       = 1'b0;
`ifdef PCILEECH_FTDI_WORKAROUND_EN
    armed_nxt = armed;
    mcnt_nxt  = mcnt;
    idle_nxt  = 8'd0;
`endif
    unique case (state)
      IDLE: begin
        if (occ != 2'd0) begin
          state_nxt = DATA;
          idx_nxt   = '0;
`ifdef PCILEECH_FTDI_WORKAROUND_EN
          if (armed) begin
            state_nxt = PREAMBLE;
            armed_nxt = 1'b0;
            mcnt_nxt  = 4'd0;
          end
`endif
        end
      end
`ifdef PCILEECH_FTDI_WORKAROUND_EN
      PREAMBLE: begin
        if (rd_acc) begin
          dout_nxt = MAGIC_WORD;
          mcnt_nxt = mcnt + 4'd1;
          if (mcnt == 4'(MAGIC_COUNT - 1)) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end
        end
      end
`endif
      DATA: begin
        if (rd_acc) begin
          dout_nxt = beat_word(head, idx);
          idx_nxt  = idx + 3'd1;
          if (idx == 3'd7) begin
            pop = 1'b1;
            // a beat arriving now keeps the stream gapless
            if (!(occ > 2'd1 || push)) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef PCILEECH_FTDI_WORKAROUND_EN
    if (state == IDLE && occ == 2'd0 && txe_q) begin
      idle_nxt = idle_cnt;
      if (idle_cnt != 8'(IDLE_ARM_CYCLES))
        idle_nxt = idle_cnt + 8'd1;
    end
    if (idle_nxt == 8'(IDLE_ARM_CYCLES)) armed_nxt = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      dout     <= '0;
      valid    <= 1'b0;
      run_q    <= 1'b0;
`ifdef PCILEECH_FTDI_WORKAROUND_EN
      txe_q    <= 1'b0;
      armed    <= 1'b0;
      mcnt     <= 4'd0;
      idle_cnt <= 8'd0;
`endif
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      dout     <= dout_nxt;
      valid    <= rd_acc;
      run_q    <= 1'b1;
`ifdef PCILEECH_FTDI_WORKAROUND_EN
      txe_q    <= ft601_txe_n;
      armed    <= armed_nxt;
      mcnt     <= mcnt_nxt;
      idle_cnt <= idle_nxt;
`endif
    end
  end

endmodule
